// File: rtl/led_sequencer.sv
// LED pattern sequencer: divider-paced or step-driven pattern engine
// with rotate, bounce and blink modes plus a power indicator.
module led_sequencer #(
  parameter int N_LEDS  = 4,
  parameter int DIV_MAX = 12000000,
  parameter int DIV_W   = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              step,
  output logic [N_LEDS-1:0] led,
  output logic              pwr_led,
  output logic              tick
);

  typedef enum logic [1:0] {
    M_DOWN   = 2'b00,
    M_UP     = 2'b01,
    M_BOUNCE = 2'b10,
    M_BLINK  = 2'b11
  } mode_t;

  localparam logic [DIV_W-1:0]  LP_MAX = DIV_W'(DIV_MAX);
  localparam logic [N_LEDS-1:0] LP_ONE = N_LEDS'(1);

  logic [DIV_W-1:0]  r_cnt;
  logic [N_LEDS-1:0] r_led;
  mode_t             r_mode;
  logic              r_dn;
  logic              r_init;
  logic              r_tick;

  mode_t             w_mode;
  logic              w_term;
  logic              w_adv;
  logic [N_LEDS-1:0] w_nxt_led;
  logic              w_nxt_dn;

  assign w_mode = mode_t'(mode);
  assign w_term = en && (r_cnt == LP_MAX);
  assign w_adv  = r_init && (w_term || step);

  // Next pattern and bounce direction for an advance event.
  always_comb begin
    w_nxt_led = r_led;
    w_nxt_dn  = r_dn;
    if (w_mode != r_mode) begin
      w_nxt_led = (w_mode == M_BLINK) ? '1 : LP_ONE;
      w_nxt_dn  = 1'b0;
    end else begin
      unique case (r_mode)
        M_DOWN:
          w_nxt_led = {r_led[0], r_led[N_LEDS-1:1]};
        M_UP:
          w_nxt_led = {r_led[N_LEDS-2:0], r_led[N_LEDS-1]};
        M_BOUNCE: begin
          if (!r_dn) begin
            if (r_led[N_LEDS-1]) begin
              w_nxt_dn  = 1'b1;
              w_nxt_led = r_led >> 1;
            end else begin
              w_nxt_led = r_led << 1;
            end
          end else begin
            if (r_led[0]) begin
              w_nxt_dn  = 1'b0;
              w_nxt_led = r_led << 1;
            end else begin
              w_nxt_led = r_led >> 1;
            end
          end
        end
        M_BLINK:
          w_nxt_led = ~r_led;
        default:
          w_nxt_led = r_led;
      endcase
    end
  end

  // Init load after reset, then divider and pattern state updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_led  <= '0;
      r_mode <= M_DOWN;
      r_dn   <= 1'b0;
      r_init <= 1'b0;
      r_tick <= 1'b0;
    end else if (!r_init) begin
      r_init <= 1'b1;
      r_led  <= LP_ONE;
    end else begin
      if (en) begin
        r_cnt <= (r_cnt == LP_MAX) ? '0 : r_cnt + 1'b1;
      end
      r_tick <= w_adv;
      if (w_adv) begin
        r_mode <= w_mode;
        r_led  <= w_nxt_led;
        r_dn   <= w_nxt_dn;
      end
    end
  end

  assign led     = r_led;
  assign tick    = r_tick;
  assign pwr_led = rst_n;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer (N_LEDS=4, DIV_MAX=3):
// expected patterns are queued, a monitor checks them on each tick.
module tb_led_sequencer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       step;
  logic [3:0] led;
  logic       pwr_led;
  logic       tick;

  int n_pass;
  int n_total;
  int n_ticks;
  int cyc;
  int last_tick_cyc;
  int ref_cyc;
  int t0;
  logic [3:0] q[$];

  led_sequencer #(
    .N_LEDS (4),
    .DIV_MAX(3),
    .DIV_W  (24)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .step   (step),
    .led    (led),
    .pwr_led(pwr_led),
    .tick   (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every tick pops one expected pattern.
  always @(negedge clk) begin
    logic [3:0] e;
    cyc++;
    if (rst_n && tick) begin
      n_ticks++;
      last_tick_cyc = cyc;
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_tick: led %0h with empty queue", led);
      end else begin
        e = q.pop_front();
        chk("led_on_tick", int'(led), int'(e));
      end
    end
  end

  task automatic wait_until(input int tgt);
    int b;
    b = 0;
    while (n_ticks < tgt && b < 64) begin
      @(negedge clk);
      #1;
      b++;
    end
    chk("tick_timeout", int'(n_ticks >= tgt), 1);
  endtask

  task automatic push4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    q.push_back(a);
    q.push_back(b);
    q.push_back(c);
    q.push_back(d);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    n_ticks = 0;
    cyc = 0;
    last_tick_cyc = 0;
    rst_n = 1'b0;
    en = 1'b0;
    mode = 2'b00;
    step = 1'b0;

    #23;
    chk("rst_led", int'(led), 0);
    chk("rst_pwr", int'(pwr_led), 0);
    chk("rst_tick", int'(tick), 0);

    @(negedge clk); #1;
    rst_n = 1'b1;
    en = 1'b1;
    @(negedge clk); #1;
    ref_cyc = cyc;
    chk("init_led", int'(led), 1);
    chk("init_pwr", int'(pwr_led), 1);
    chk("init_tick", int'(tick), 0);

    // rotate-down
    push4(4'b1000, 4'b0100, 4'b0010, 4'b0001);
    wait_until(1);
    chk("first_adv_lat", last_tick_cyc - ref_cyc, 4);
    ref_cyc = last_tick_cyc;
    wait_until(2);
    chk("auto_period", last_tick_cyc - ref_cyc, 4);
    wait_until(4);

    // rotate-up with reload
    mode = 2'b01;
    q.push_back(4'b0001);
    push4(4'b0010, 4'b0100, 4'b1000, 4'b0001);
    wait_until(9);

    // bounce
    mode = 2'b10;
    push4(4'b0001, 4'b0010, 4'b0100, 4'b1000);
    push4(4'b0100, 4'b0010, 4'b0001, 4'b0010);
    wait_until(17);

    // blink, then freeze divider at count 1 and single-step
    mode = 2'b11;
    q.push_back(4'b1111);
    q.push_back(4'b0000);
    q.push_back(4'b1111);
    wait_until(20);
    @(negedge clk); #1;
    en = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("frozen_led", int'(led), 4'hf);
    chk("frozen_ticks", n_ticks, 20);
    q.push_back(4'b0000);
    step = 1'b1;
    @(negedge clk); #1;
    step = 1'b0;
    wait_until(21);
    repeat (5) @(negedge clk);
    #1;
    chk("step1_once", n_ticks, 21);
    q.push_back(4'b1111);
    step = 1'b1;
    @(negedge clk); #1;
    step = 1'b0;
    wait_until(22);
    repeat (5) @(negedge clk);
    #1;
    chk("step2_once", n_ticks, 22);

    // divider resumes from the frozen count
    q.push_back(4'b0000);
    ref_cyc = cyc;
    en = 1'b1;
    wait_until(23);
    chk("resume_lat", last_tick_cyc - ref_cyc, 3);

    // step coincident with terminal count
    repeat (3) @(negedge clk);
    #1;
    q.push_back(4'b1111);
    step = 1'b1;
    @(negedge clk); #1;
    step = 1'b0;
    wait_until(24);
    chk("coincide_lat", last_tick_cyc - ref_cyc, 7);
    t0 = last_tick_cyc;
    q.push_back(4'b0000);
    wait_until(25);
    chk("after_coincide", last_tick_cyc - t0, 4);

    // bounce, then asynchronous reset mid-sequence
    mode = 2'b10;
    q.push_back(4'b0001);
    q.push_back(4'b0010);
    q.push_back(4'b0100);
    wait_until(28);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_led", int'(led), 0);
    chk("async_pwr", int'(pwr_led), 0);
    chk("async_tick", int'(tick), 0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("reinit_led", int'(led), 1);
    q.push_back(4'b0001);
    push4(4'b0010, 4'b0100, 4'b1000, 4'b0100);
    wait_until(33);

    repeat (2) @(negedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
